// File: rtl/bc_en_rc_dff_pipe.sv
// bc_en_rc_dff_pipe: DEPTH-stage elastic register pipeline with valid/ready
// handshake on both sides, bubble collapsing, synchronous flush and an
// occupancy count. Stage 0 is the input side, stage DEPTH-1 drives oVld/oDat.
module bc_en_rc_dff_pipe #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 3,
  parameter logic [WIDTH-1:0] INI_DATA = '0,
  parameter int               CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iFlush,
  input  logic             iVld,
  output logic             oRdy,
  input  logic [WIDTH-1:0] iDat,
  output logic             oVld,
  input  logic             iRdy,
  output logic [WIDTH-1:0] oDat,
  output logic [CW-1:0]    oCnt
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("bc_en_rc_dff_pipe: DEPTH must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("bc_en_rc_dff_pipe: WIDTH must be >= 1");
  end

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat     [DEPTH];
  logic [CW-1:0]    cnt;
  logic [DEPTH:0]   pass;
  logic [DEPTH-1:0] src_vld;
  logic [WIDTH-1:0] src_dat [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  // Pass chain: a stage may load when it is empty or everything ahead moves.
  always_comb begin
    pass        = '0;
    pass[DEPTH] = iRdy;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      pass[k] = !vld[k] || pass[k + 1];
    end
  end

  // Source of each stage: the upstream port for stage 0, the previous stage otherwise.
  always_comb begin
    src_vld[0] = iVld;
    src_dat[0] = iDat;
    for (int k = 1; k < DEPTH; k++) begin
      src_vld[k] = vld[k - 1];
      src_dat[k] = dat[k - 1];
    end
  end

  assign oRdy     = pass[0] && !iFlush;
  assign in_xfer  = iVld && oRdy;
  assign out_xfer = vld[DEPTH - 1] && iRdy && !iFlush;

  // ---- stage boundary: valid bits and occupancy count ----
  // Valid bits advance wherever the pass chain allows; flush and reset empty the pipe.
  always_ff @(posedge clk) begin
    if (rst || iFlush) begin
      vld <= '0;
      cnt <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (pass[k]) vld[k] <= src_vld[k];
      end
      cnt <= cnt + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  // ---- stage boundary: payload registers ----
  // Payload loads only from a valid source so idle stages do not toggle; flush keeps data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) dat[k] <= INI_DATA;
    end else if (!iFlush) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (pass[k] && src_vld[k]) dat[k] <= src_dat[k];
      end
    end
  end

  assign oVld = vld[DEPTH - 1];
  assign oDat = dat[DEPTH - 1];
  assign oCnt = cnt;

endmodule

// File: tb/tb_bc_en_rc_dff_pipe.sv
// Self-checking bench for bc_en_rc_dff_pipe: three instances (DEPTH 3/1/5)
// share one stimulus stream; each has a queue-based scoreboard model.
module tb_bc_en_rc_dff_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ivld;
  logic        irdy;
  logic [31:0] idat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int D = (g == 0) ? 3 : (g == 1) ? 1 : 5;
    localparam int W = (g == 2) ? 7 : 32;
    localparam int CWL = $clog2(D + 1);
    localparam logic [W-1:0] INI = 1;

    logic           ordy;
    logic           ovld;
    logic [W-1:0]   odat;
    logic [CWL-1:0] ocnt;

    bc_en_rc_dff_pipe #(.WIDTH(W), .DEPTH(D), .INI_DATA(INI)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .iFlush(flush),
      .iVld  (ivld),
      .oRdy  (ordy),
      .iDat  (idat[W-1:0]),
      .oVld  (ovld),
      .iRdy  (irdy),
      .oDat  (odat),
      .oCnt  (ocnt)
    );

    // Scoreboard contents: payload and the edge at which it reaches the output.
    // The oldest item never waits on anything ahead of it, so it arrives
    // DEPTH-1 edges after acceptance regardless of backpressure.
    logic [W-1:0] qd [$];
    int           qt [$];
    int           t     = 0;
    bit           live  = 1'b0;
    logic [W-1:0] lastd = INI;

    // Model update at each edge: accept/emit per handshake rules, clear on flush/reset.
    always @(posedge clk) begin : model
      bit ev;
      bit er;
      ev = (qd.size() > 0) && (t >= qt[0]);
      er = ((qd.size() < D) || irdy) && !flush;
      t  = t + 1;
      if (ev) lastd = qd[0];
      if (rst) begin
        qd.delete();
        qt.delete();
        live  = 1'b1;
        lastd = INI;
      end else if (live) begin
        if (flush) begin
          qd.delete();
          qt.delete();
        end else begin
          if (ev && irdy) begin
            void'(qd.pop_front());
            void'(qt.pop_front());
          end
          if (ivld && er) begin
            qd.push_back(idat[W-1:0]);
            qt.push_back(t + D - 1);
          end
        end
      end
    end

    // Monitor: compare DUT outputs with the scoreboard away from the active edge.
    always @(negedge clk) begin : monitor
      bit           ev;
      bit           er;
      logic [W-1:0] ed;
      if (live) begin
        ev = (qd.size() > 0) && (t >= qt[0]);
        er = ((qd.size() < D) || irdy) && !flush;
        ed = ev ? qd[0] : lastd;
        chk("oRdy", g, 32'(ordy), 32'(er));
        chk("oVld", g, 32'(ovld), 32'(ev));
        chk("oDat", g, 32'(odat), 32'(ed));
        chk("oCnt", g, 32'(ocnt), qd.size());
        chk("popcount", g, $countones(u_dut.vld), qd.size());
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic r,
                       input logic f, input logic rs);
    ivld  = v;
    idat  = d;
    irdy  = r;
    flush = f;
    rst   = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 1, 0, 1);
    chk("rst_oDat", 0, gi[0].odat, 32'h1);
    chk("rst_oVld", 0, 32'(gi[0].ovld), 0);
    chk("rst_oRdy", 0, 32'(gi[0].ordy), 1);
    drive(0, 0, 1, 0, 0);

    // Streaming with iRdy=1
    for (int i = 0; i < 8; i++) drive(1, 32'h10 + i, 1, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 0);

    // Backpressure: A,B,C fill, D waits until iRdy rises
    drive(1, 32'hA, 0, 0, 0);
    drive(1, 32'hB, 0, 0, 0);
    drive(1, 32'hC, 0, 0, 0);
    drive(1, 32'hD, 0, 0, 0);
    chk("full_oCnt", 0, 32'(gi[0].ocnt), 3);
    chk("full_oDat", 0, gi[0].odat, 32'hA);
    drive(1, 32'hD, 0, 0, 0);
    drive(1, 32'hD, 1, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0, 0);

    // Bubble collapse
    drive(1, 32'h2A, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 32'h2B, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("bubble_vld", 0, 32'(gi[0].u_dut.vld), 32'b110);
    chk("bubble_dat0", 0, gi[0].u_dut.dat[0], 32'h2B);
    chk("bubble_oCnt", 0, 32'(gi[0].ocnt), 2);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0, 0);

    // Flush with items in flight while iVld=1
    drive(1, 32'h31, 0, 0, 0);
    drive(1, 32'h32, 0, 0, 0);
    drive(1, 32'h33, 0, 0, 0);
    drive(1, 32'h34, 1, 1, 0);
    chk("flush_oVld", 0, 32'(gi[0].ovld), 0);
    chk("flush_oCnt", 0, 32'(gi[0].ocnt), 0);
    for (int i = 0; i < 4; i++) drive(1, 32'h40 + i, 1, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0, 0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 1), $urandom, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
